// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Output of the one-bit full-adder slice
   typedef struct packed {
      logic co;
      logic s;
   } fa_out_t;

endpackage : serial_adder_ctrl_pkg

// File: rtl/halfadder.sv
// One-bit half adder, the basic combinational datapath cell.
module halfadder (
   input  logic a_i,
   input  logic b_i,
   output logic sum_c,
   output logic carry_c
);

   assign sum_c   = a_i ^ b_i;
   assign carry_c = a_i & b_i;

endmodule : halfadder

// File: rtl/serial_adder_full_adder_bit.sv
// One-bit full adder built from two half adders and an OR gate.
module full_adder_bit
   import serial_adder_ctrl_pkg::*;
(
   input  logic    a_i,
   input  logic    b_i,
   input  logic    c_i,
   output fa_out_t fa_c
);

   logic s1, c1, s2, c2;

   halfadder u_ha0 (
      .a_i     (a_i),
      .b_i     (b_i),
      .sum_c   (s1),
      .carry_c (c1)
   );

   halfadder u_ha1 (
      .a_i     (s1),
      .b_i     (c_i),
      .sum_c   (s2),
      .carry_c (c2)
   );

   assign fa_c.s  = s2;
   assign fa_c.co = c1 | c2;

endmodule : full_adder_bit

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first through one full-adder
// slice, presenting a registered sum, carry-out and a one-cycle done pulse.
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             done
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   sa_q, sa_d;
   logic [WIDTH-1:0]   sb_q, sb_d;
   logic [WIDTH-1:0]   sr_q, sr_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               c_q, c_d;
   logic               cout_q, cout_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   fa_out_t            fa;

   full_adder_bit u_fa (
      .a_i  (sa_q[0]),
      .b_i  (sb_q[0]),
      .c_i  (c_q),
      .fa_c (fa)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sa_q   <= '0;
         sb_q   <= '0;
         sr_q   <= '0;
         sum_q  <= '0;
         c_q    <= 1'b0;
         cout_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sa_q   <= sa_d;
         sb_q   <= sb_d;
         sr_q   <= sr_d;
         sum_q  <= sum_d;
         c_q    <= c_d;
         cout_q <= cout_d;
         cnt_q  <= cnt_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      sr_d    = sr_q;
      sum_d   = sum_q;
      c_d     = c_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               sa_d    = a;
               sb_d    = b;
               c_d     = 1'b0;
               cnt_d   = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            // Result bits enter at the MSB so the last bit lands the word aligned
            sr_d  = (sr_q >> 1) | (WIDTH'(fa.s) << (WIDTH - 1));
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            c_d   = fa.co;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               sum_d   = sr_d;
               cout_d  = fa.co;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
   assign busy  = (state_q == S_RUN);
   assign done  = (state_q == S_DONE);
   assign sum   = sum_q;
   assign cout  = cout_q;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: WIDTH=8 and WIDTH=1 instances checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       ready8, busy8, cout8, done8;
   logic [7:0] sum8;
   logic       start1 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0;
   logic       ready1, busy1, cout1, done1;
   logic [0:0] sum1;

   int n_checks = 0;
   int n_fail   = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .ready(ready8), .busy(busy8), .sum(sum8), .cout(cout8), .done(done8)
   );

   serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
      .ready(ready1), .busy(busy1), .sum(sum1), .cout(cout1), .done(done1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: a start seen while ready yields (a+b) WIDTH edges later
   logic       m8_ready = 1'b1, m8_done = 1'b0, m8_cout = 1'b0;
   logic [7:0] m8_sum = '0;
   logic [8:0] m8_pend = '0;
   int         m8_left = 0;
   logic       m1_ready = 1'b1, m1_done = 1'b0, m1_cout = 1'b0;
   logic [0:0] m1_sum = '0;
   logic [1:0] m1_pend = '0;
   int         m1_left = 0;

   always @(posedge clk) begin
      if (rst) begin
         m8_ready <= 1'b1; m8_left <= 0; m8_sum <= '0; m8_cout <= 1'b0; m8_done <= 1'b0;
      end else if (m8_left != 0) begin
         m8_left <= m8_left - 1;
         if (m8_left == 1) begin
            {m8_cout, m8_sum} <= m8_pend;
            m8_done  <= 1'b1;
            m8_ready <= 1'b1;
         end
      end else begin
         m8_done <= 1'b0;
         if (start8) begin
            m8_pend  <= 9'(a8) + 9'(b8);
            m8_left  <= 8;
            m8_ready <= 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         m1_ready <= 1'b1; m1_left <= 0; m1_sum <= '0; m1_cout <= 1'b0; m1_done <= 1'b0;
      end else if (m1_left != 0) begin
         m1_left <= m1_left - 1;
         if (m1_left == 1) begin
            {m1_cout, m1_sum} <= m1_pend;
            m1_done  <= 1'b1;
            m1_ready <= 1'b1;
         end
      end else begin
         m1_done <= 1'b0;
         if (start1) begin
            m1_pend  <= 2'(a1) + 2'(b1);
            m1_left  <= 1;
            m1_ready <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("ready8", 32'(ready8), 32'(m8_ready));
         check("busy8",  32'(busy8),  32'(!m8_ready));
         check("done8",  32'(done8),  32'(m8_done));
         check("sum8",   32'(sum8),   32'(m8_sum));
         check("cout8",  32'(cout8),  32'(m8_cout));
         check("ready1", 32'(ready1), 32'(m1_ready));
         check("busy1",  32'(busy1),  32'(!m1_ready));
         check("done1",  32'(done1),  32'(m1_done));
         check("sum1",   32'(sum1),   32'(m1_sum));
         check("cout1",  32'(cout1),  32'(m1_cout));
      end
   end

   task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] es, input logic ec);
      int n;
      @(negedge clk);
      a8 = av; b8 = bv; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      n = 0;
      while (done8 !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("lat8", 32'(n), 32'd8);
      check("lit_sum8", 32'(sum8), 32'(es));
      check("lit_cout8", 32'(cout8), 32'(ec));
   endtask

   task automatic run1(input logic av, input logic bv, input logic [1:0] exp);
      int n;
      @(negedge clk);
      a1 = av; b1 = bv; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (done1 !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("lat1", 32'(n), 32'd1);
      check("lit_cs1", 32'({cout1, sum1}), 32'(exp));
   endtask

   initial begin
      int pulses;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_sum8", 32'(sum8), 32'h0);
      check("rst_ready8", 32'(ready8), 32'h1);
      check("rst_done8", 32'(done8), 32'h0);
      chk_en = 1'b1;

      run8(8'h35, 8'h4A, 8'h7F, 1'b0);
      @(negedge clk);
      check("ready_after8", 32'(ready8), 32'h1);
      run8(8'hFF, 8'h01, 8'h00, 1'b1);
      run8(8'h80, 8'h80, 8'h00, 1'b1);
      run8(8'h00, 8'h00, 8'h00, 1'b0);

      // start held through RUN with changing operands
      @(negedge clk);
      a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         a8 = 8'h77; b8 = 8'h11;
      end
      @(negedge clk);
      start8 = 1'b0;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         if (done8 === 1'b1) begin
            pulses++;
            check("held_sum8", 32'(sum8), 32'h46);
         end
         @(negedge clk);
      end
      check("held_pulses", 32'(pulses), 32'd1);

      // back-to-back start in the DONE cycle
      run8(8'h21, 8'h43, 8'h64, 1'b0);
      a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      pulses = 0;
      while (done8 !== 1'b1 && pulses < 20) begin
         check("b2b_hold8", 32'(sum8), 32'h64);
         @(negedge clk);
         pulses++;
      end
      check("b2b_lat8", 32'(pulses), 32'd8);
      check("b2b_sum8", 32'(sum8), 32'h30);

      // reset in the 4th RUN cycle
      @(negedge clk);
      a8 = 8'h55; b8 = 8'h22; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mrst_ready8", 32'(ready8), 32'h1);
      check("mrst_sum8", 32'({cout8, sum8}), 32'h0);
      check("mrst_done8", 32'(done8), 32'h0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done8 === 1'b1) pulses++;
      end
      check("mrst_pulses", 32'(pulses), 32'd0);
      run8(8'h0F, 8'h01, 8'h10, 1'b0);

      run1(1'b0, 1'b0, 2'b00);
      run1(1'b0, 1'b1, 2'b01);
      run1(1'b1, 1'b0, 2'b01);
      run1(1'b1, 1'b1, 2'b10);

      repeat (3) @(negedge clk);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule : tb_serial_adder_ctrl
